// File: rtl/syscall_responder_if.sv
// syscall_responder_if: datapath <-> syscall responder bundle.
// Memory read port exists only with `SYSCALL_PRINT_STR_EN`.
interface syscall_responder_if;
   logic        syscall_req;
   logic [31:0] v0_data;
   logic [31:0] a0_data;
   logic        stall;
   logic        done;
   logic        result_we;
   logic [31:0] result_data;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        halted;
   logic        bad_code;
`ifdef SYSCALL_PRINT_STR_EN
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output syscall_req, v0_data, a0_data, tx_ready,
      output mem_rdata, mem_ack,
      input  stall, done, result_we, result_data,
      input  tx_valid, tx_data, halted, bad_code,
      input  mem_req, mem_addr
   );

   modport slave (
      input  syscall_req, v0_data, a0_data, tx_ready,
      input  mem_rdata, mem_ack,
      output stall, done, result_we, result_data,
      output tx_valid, tx_data, halted, bad_code,
      output mem_req, mem_addr
   );
`else
   modport master (
      output syscall_req, v0_data, a0_data, tx_ready,
      input  stall, done, result_we, result_data,
      input  tx_valid, tx_data, halted, bad_code
   );

   modport slave (
      input  syscall_req, v0_data, a0_data, tx_ready,
      output stall, done, result_we, result_data,
      output tx_valid, tx_data, halted, bad_code
   );
`endif
endinterface

// File: rtl/syscall_responder.sv
// syscall_responder: services print int/char, sbrk, exit syscalls.
// Print string (code 4) is built only with `SYSCALL_PRINT_STR_EN`.
module syscall_responder #(
   parameter logic [31:0] HEAP_BASE = 32'h10000000,
   parameter logic [31:0] HEAP_SIZE = 32'h000000fc
) (
   input  logic               clk,
   input  logic               reset,
   syscall_responder_if.slave bus
);
   localparam logic [32:0] HEAP_LIM =
      {1'b0, HEAP_BASE} + {1'b0, HEAP_SIZE};

   typedef enum logic [2:0] {
      IDLE, DECODE, INT_SIGN, INT_DIGIT,
      TX_CHAR, STR_FETCH, STR_EMIT, FINISH
   } state_t;

   state_t      state;
   state_t      ret;
   logic [31:0] code;
   logic [31:0] arg;
   logic [31:0] mag;
   logic [31:0] heap_ptr;
   logic [3:0]  pos;
   logic [3:0]  digit;
   logic        started;
   logic [31:0] n_round;
   logic [32:0] heap_end;
   logic [31:0] pow;
`ifdef SYSCALL_PRINT_STR_EN
   logic [31:0] word;
   logic [7:0]  lane;
`endif

   function automatic logic [31:0] pow10(input logic [3:0] p);
      case (p)
         4'd9:    pow10 = 32'd1000000000;
         4'd8:    pow10 = 32'd100000000;
         4'd7:    pow10 = 32'd10000000;
         4'd6:    pow10 = 32'd1000000;
         4'd5:    pow10 = 32'd100000;
         4'd4:    pow10 = 32'd10000;
         4'd3:    pow10 = 32'd1000;
         4'd2:    pow10 = 32'd100;
         4'd1:    pow10 = 32'd10;
         default: pow10 = 32'd1;
      endcase
   endfunction

   assign bus.stall = bus.syscall_req & ~bus.done;

   // sbrk size rounding, heap end and current decimal weight
   always_comb begin
      n_round  = (arg + 32'd3) & ~32'd3;
      heap_end = {1'b0, heap_ptr} + {1'b0, n_round};
      pow      = pow10(pos);
   end

`ifdef SYSCALL_PRINT_STR_EN
   // little-endian byte lane of the fetched word
   always_comb begin
      case (arg[1:0])
         2'd0:    lane = word[7:0];
         2'd1:    lane = word[15:8];
         2'd2:    lane = word[23:16];
         default: lane = word[31:24];
      endcase
   end
`endif

   // service FSM with registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         ret             <= IDLE;
         code            <= '0;
         arg             <= '0;
         mag             <= '0;
         heap_ptr        <= HEAP_BASE;
         pos             <= '0;
         digit           <= '0;
         started         <= 1'b0;
         bus.done        <= 1'b0;
         bus.result_we   <= 1'b0;
         bus.result_data <= '0;
         bus.tx_valid    <= 1'b0;
         bus.tx_data     <= '0;
         bus.halted      <= 1'b0;
         bus.bad_code    <= 1'b0;
`ifdef SYSCALL_PRINT_STR_EN
         bus.mem_req     <= 1'b0;
         bus.mem_addr    <= '0;
         word            <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.syscall_req && !bus.halted) begin
                  code  <= bus.v0_data;
                  arg   <= bus.a0_data;
                  state <= DECODE;
               end
            end
            DECODE: begin
               case (code)
                  32'd1: state <= INT_SIGN;
                  32'd11: begin
                     bus.tx_valid <= 1'b1;
                     bus.tx_data  <= arg[7:0];
                     ret          <= FINISH;
                     state        <= TX_CHAR;
                  end
                  32'd9: begin
                     bus.done      <= 1'b1;
                     bus.result_we <= 1'b1;
                     state         <= FINISH;
                     if (heap_end <= HEAP_LIM) begin
                        bus.result_data <= heap_ptr;
                        heap_ptr        <= heap_end[31:0];
                     end else begin
                        bus.result_data <= 32'hFFFFFFFF;
                     end
                  end
                  32'd10: begin
                     bus.halted <= 1'b1;
                     bus.done   <= 1'b1;
                     state      <= FINISH;
                  end
`ifdef SYSCALL_PRINT_STR_EN
                  32'd4: begin
                     bus.mem_req  <= 1'b1;
                     bus.mem_addr <= {arg[31:2], 2'b00};
                     state        <= STR_FETCH;
                  end
`endif
                  default: begin
                     bus.done     <= 1'b1;
                     bus.bad_code <= 1'b1;
                     state        <= FINISH;
                  end
               endcase
            end
            INT_SIGN: begin
               pos     <= 4'd9;
               digit   <= 4'd0;
               started <= 1'b0;
               if (arg[31]) begin
                  mag          <= -arg;
                  bus.tx_valid <= 1'b1;
                  bus.tx_data  <= 8'h2D;
                  ret          <= INT_DIGIT;
                  state        <= TX_CHAR;
               end else begin
                  mag   <= arg;
                  state <= INT_DIGIT;
               end
            end
            INT_DIGIT: begin
               if (mag >= pow) begin
                  mag   <= mag - pow;
                  digit <= digit + 4'd1;
               end else begin
                  digit <= 4'd0;
                  pos   <= pos - 4'd1;
                  if (digit != 4'd0 || started || pos == 4'd0) begin
                     started      <= 1'b1;
                     bus.tx_valid <= 1'b1;
                     bus.tx_data  <= 8'h30 + {4'h0, digit};
                     ret   <= (pos == 4'd0) ? FINISH : INT_DIGIT;
                     state <= TX_CHAR;
                  end
               end
            end
            TX_CHAR: begin
               if (bus.tx_ready) begin
                  bus.tx_valid <= 1'b0;
                  state        <= ret;
                  if (ret == FINISH)
                     bus.done <= 1'b1;
`ifdef SYSCALL_PRINT_STR_EN
                  if (ret == STR_FETCH) begin
                     bus.mem_req  <= 1'b1;
                     bus.mem_addr <= {arg[31:2], 2'b00};
                  end
`endif
               end
            end
`ifdef SYSCALL_PRINT_STR_EN
            STR_FETCH: begin
               if (bus.mem_ack) begin
                  bus.mem_req <= 1'b0;
                  word        <= bus.mem_rdata;
                  state       <= STR_EMIT;
               end
            end
            STR_EMIT: begin
               if (lane == 8'h00) begin
                  bus.done <= 1'b1;
                  state    <= FINISH;
               end else begin
                  bus.tx_valid <= 1'b1;
                  bus.tx_data  <= lane;
                  arg          <= arg + 32'd1;
                  ret   <= (arg[1:0] == 2'd3) ? STR_FETCH : STR_EMIT;
                  state <= TX_CHAR;
               end
            end
`endif
            FINISH: begin
               bus.done      <= 1'b0;
               bus.result_we <= 1'b0;
               bus.bad_code  <= 1'b0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_syscall_responder.sv
// tb_syscall_responder: directed + random checks of syscall_responder.
// Reference model: heap arithmetic and $sformatf decimal strings.
module tb_syscall_responder;
   localparam logic [31:0] HEAP_BASE = 32'h10000000;
   localparam logic [31:0] HEAP_SIZE = 32'h000000fc;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   syscall_responder_if sif();

   syscall_responder #(
      .HEAP_BASE(HEAP_BASE),
      .HEAP_SIZE(HEAP_SIZE)
   ) dut (
      .clk(clk),
      .reset(rst_n),
      .bus(sif.slave)
   );

   always #5 clk = ~clk;

   logic [7:0] rx[$];
   longint     heap_m;
   int         first_tx;
`ifdef SYSCALL_PRINT_STR_EN
   logic [31:0] mem [0:7];
   int          mem_txn;
`endif

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] sbrk_m(input logic [31:0] a);
      logic [31:0] n;
      n = ((a + 32'd3) / 32'd4) * 32'd4;
      if (heap_m + longint'(n) <=
          longint'(HEAP_BASE) + longint'(HEAP_SIZE)) begin
         sbrk_m = heap_m[31:0];
         heap_m = heap_m + longint'(n);
      end else begin
         sbrk_m = 32'hFFFFFFFF;
      end
   endfunction

   task automatic run_sc(input logic [31:0] code,
                         input logic [31:0] arg,
                         input bit rnd, input int budget,
                         output int n, output logic we,
                         output logic [31:0] res,
                         output logic bad);
      bit         pv;
      logic [7:0] pd;
      bit         got;
      pv = 1'b0;
      pd = '0;
      got = 1'b0;
      rx.delete();
      first_tx = -1;
      n = 0;
      we = 1'b0;
      res = '0;
      bad = 1'b0;
      @(negedge clk);
      sif.syscall_req = 1'b1;
      sif.v0_data = code;
      sif.a0_data = arg;
      sif.tx_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      while (!got && n < budget) begin
         @(negedge clk);
         n++;
         if (pv) begin
            chk("tx_hold_valid", sif.tx_valid, 1'b1);
            chk("tx_hold_data", sif.tx_data, pd);
         end
         chk("stall", sif.stall, sif.syscall_req & !sif.done);
         if (sif.done) begin
            got = 1'b1;
            we  = sif.result_we;
            res = sif.result_data;
            bad = sif.bad_code;
            sif.syscall_req = 1'b0;
         end else begin
`ifdef SYSCALL_PRINT_STR_EN
            sif.mem_ack = sif.mem_req && ($urandom_range(0, 1) == 1);
            if (sif.mem_ack) begin
               sif.mem_rdata = mem[sif.mem_addr[4:2]];
               mem_txn++;
            end
`endif
            sif.tx_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (sif.tx_valid && sif.tx_ready) begin
               rx.push_back(sif.tx_data);
               if (first_tx < 0) first_tx = n;
            end
            pv = sif.tx_valid && !sif.tx_ready;
            pd = sif.tx_data;
         end
      end
      chk("done_seen", got, 1'b1);
      sif.syscall_req = 1'b0;
      sif.tx_ready = 1'b1;
`ifdef SYSCALL_PRINT_STR_EN
      sif.mem_ack = 1'b0;
`endif
   endtask

   task automatic do_sbrk(input logic [31:0] a);
      int n;
      logic we, bad;
      logic [31:0] res, exp;
      exp = sbrk_m(a);
      run_sc(32'd9, a, 1'b0, 20, n, we, res, bad);
      chk("sbrk_result", res, exp);
      chk("sbrk_we", we, 1'b1);
      chk("sbrk_bad", bad, 1'b0);
      chk("sbrk_latency", n, 2);
   endtask

   task automatic do_int(input logic [31:0] a, input bit rnd);
      int n;
      logic we, bad;
      logic [31:0] res;
      string s;
      s = $sformatf("%0d", $signed(a));
      run_sc(32'd1, a, rnd, 600, n, we, res, bad);
      chk("int_len", rx.size(), s.len());
      for (int i = 0; i < s.len() && i < rx.size(); i++)
         chk("int_byte", rx[i], s[i]);
      chk("int_we", we, 1'b0);
      if (!rnd) chk("int_bound", n <= 110, 1'b1);
   endtask

   initial begin
      int n;
      int k;
      logic we, bad;
      logic [31:0] res;

      rst_n = 1'b0;
      sif.syscall_req = 1'b1;
      sif.v0_data = '0;
      sif.a0_data = '0;
      sif.tx_ready = 1'b1;
`ifdef SYSCALL_PRINT_STR_EN
      sif.mem_ack = 1'b0;
      sif.mem_rdata = '0;
      mem_txn = 0;
      for (int i = 0; i < 8; i++) mem[i] = '0;
`endif
      heap_m = longint'(HEAP_BASE);
      repeat (3) @(negedge clk);
      chk("rst_stall_hi", sif.stall, 1'b1);
      sif.syscall_req = 1'b0;
      #1;
      chk("rst_stall_lo", sif.stall, 1'b0);
      chk("rst_done", sif.done, 1'b0);
      chk("rst_we", sif.result_we, 1'b0);
      chk("rst_rdata", sif.result_data, 32'h0);
      chk("rst_tx_valid", sif.tx_valid, 1'b0);
      chk("rst_tx_data", sif.tx_data, 8'h00);
      chk("rst_halted", sif.halted, 1'b0);
      chk("rst_bad", sif.bad_code, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      do_sbrk(32'd5);
      do_sbrk(32'hF8);
      do_sbrk(32'hF4);
      do_sbrk(32'd4);
      do_sbrk(32'd0);

      run_sc(32'd11, 32'h1234_5641, 1'b0, 20, n, we, res, bad);
      chk("chr_len", rx.size(), 1);
      chk("chr_byte", rx.size() > 0 ? rx[0] : 8'hxx, 8'h41);
      chk("chr_tx_cycle", first_tx, 2);
      chk("chr_latency", n, 3);
      chk("chr_we", we, 1'b0);

      do_int(32'hFFFFFF85, 1'b0);
      do_int(32'h0, 1'b0);
      do_int(32'h80000000, 1'b0);
      do_int(32'h7FFFFFFF, 1'b0);
      do_int(32'd1000000000, 1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) do_int($urandom, 1'b1);
         else do_int(-$urandom_range(0, 999), 1'b1);
      end

      run_sc(32'd77, 32'd3, 1'b0, 20, n, we, res, bad);
      chk("unk_bad", bad, 1'b1);
      chk("unk_we", we, 1'b0);
      chk("unk_latency", n, 2);
      chk("unk_no_tx", rx.size(), 0);

`ifdef SYSCALL_PRINT_STR_EN
      mem[0] = 32'h6948_0000;
      mem[1] = 32'h0000_0000;
      mem_txn = 0;
      run_sc(32'd4, 32'h10000002, 1'b1, 200, n, we, res, bad);
      chk("str_len", rx.size(), 2);
      chk("str_b0", rx.size() > 0 ? rx[0] : 8'hxx, 8'h48);
      chk("str_b1", rx.size() > 1 ? rx[1] : 8'hxx, 8'h69);
      chk("str_txn", mem_txn, 2);
      chk("str_bad", bad, 1'b0);
`else
      run_sc(32'd4, 32'h10000002, 1'b0, 20, n, we, res, bad);
      chk("str_off_bad", bad, 1'b1);
      chk("str_off_no_tx", rx.size(), 0);
`endif

      for (int i = 0; i < 4; i++) do_sbrk($urandom_range(0, 64));

      rx.delete();
      @(negedge clk);
      sif.syscall_req = 1'b1;
      sif.v0_data = 32'd1;
      sif.a0_data = 32'hFFFFFF85;
      sif.tx_ready = 1'b1;
      k = 0;
      while (rx.size() < 2 && k < 60) begin
         @(negedge clk);
         k++;
         if (sif.tx_valid && sif.tx_ready) rx.push_back(sif.tx_data);
      end
      chk("abort_two_bytes", rx.size(), 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_done", sif.done, 1'b0);
      chk("abort_we", sif.result_we, 1'b0);
      chk("abort_rdata", sif.result_data, 32'h0);
      chk("abort_tx_valid", sif.tx_valid, 1'b0);
      chk("abort_tx_data", sif.tx_data, 8'h00);
      chk("abort_bad", sif.bad_code, 1'b0);
      chk("abort_stall", sif.stall, 1'b1);
      sif.syscall_req = 1'b0;
      heap_m = longint'(HEAP_BASE);
      @(negedge clk);
      rst_n = 1'b1;

      do_sbrk(32'd5);
      do_sbrk(32'd4);

      run_sc(32'd10, 32'd0, 1'b0, 20, n, we, res, bad);
      chk("exit_latency", n, 2);
      chk("exit_we", we, 1'b0);
      chk("exit_bad", bad, 1'b0);
      #1;
      chk("exit_halted", sif.halted, 1'b1);

      @(negedge clk);
      sif.syscall_req = 1'b1;
      sif.v0_data = 32'd11;
      sif.a0_data = 32'h41;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("halt_no_done", sif.done, 1'b0);
         chk("halt_stall", sif.stall, 1'b1);
         chk("halt_no_tx", sif.tx_valid, 1'b0);
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("halt_cleared", sif.halted, 1'b0);
      sif.syscall_req = 1'b0;
      heap_m = longint'(HEAP_BASE);
      @(negedge clk);
      rst_n = 1'b1;

      do_sbrk(32'd12);
      do_int(32'd42, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule

// File: doc/syscall_responder.md
# syscall_responder

Services MIPS `syscall` instructions issued by the single-cycle datapath. The block is the responder end of the datapath's syscall interface: it accepts the $v0 service code and $a0 argument, stalls the PC until the service completes, and returns a $v0 result write for sbrk. It also owns the heap pointer, a byte-stream console transmitter, and the sticky halt flag. It sits between the datapath's `v0_data`/`a0_data` outputs and the console/memory side of the top level.

## Interface
- `HEAP_BASE`, 32'h10000000, first heap byte address; reset value of the heap pointer.
- `HEAP_SIZE`, 32'h000000fc, heap size in bytes; the heap limit is `HEAP_BASE + HEAP_SIZE` (exclusive).
- `clk  in  1`  system clock; all state updates on the rising edge.
- `reset  in  1`  asynchronous, active-low reset.
- `syscall_req  in  1`  high while the current instruction is `syscall`; held while `stall`=1.
- `v0_data  in  32`  service code.
- `a0_data  in  32`  argument.
- `stall  out  1`  equals `syscall_req & ~done`; holds the PC.
- `done  out  1`  one-cycle pulse; the service is complete and the PC advances.
- `result_we  out  1`  pulses with `done` for sbrk only; write `result_data` to $v0.
- `result_data  out  32`  sbrk return value.
- `tx_valid  out  1`, `tx_data  out  8`, `tx_ready  in  1`  console byte stream; a byte transfers on a cycle with `tx_valid & tx_ready`.
- `halted  out  1`  sticky; set by exit.
- `bad_code  out  1`  pulses with `done` for an unsupported code.
- `mem_req  out  1`, `mem_addr  out  32`, `mem_rdata  in  32`, `mem_ack  in  1`  word read port; present only under the macro below.

## Operation
- FSM states: IDLE, DECODE, INT_SIGN, INT_DIGIT, TX_CHAR, STR_FETCH, STR_EMIT, FINISH.
- IDLE:
  - Ignores `syscall_req` while `halted`=1.
  - Otherwise, when `syscall_req`=1, latches `v0_data`/`a0_data` and moves to DECODE.
- Code 1, print signed int:
  - For a negative value, emits '-' (0x2D), then works on the unsigned magnitude. 0x80000000 prints "-2147483648".
  - Digits are produced by repeated subtraction of 10^9 down to 10^0, one subtraction per cycle.
  - Leading zeros are suppressed. A value of 0 prints "0".
  - Each digit is 0x30+d.
- Code 11, print char: emits `a0[7:0]`.
- Code 9, sbrk:
  - `n` = `a0` rounded up to a multiple of 4 (32-bit wrap ignored).
  - If `heap_ptr + n` is no greater than the heap limit: `result_data` = old `heap_ptr`, and `heap_ptr` advances by `n`.
  - Otherwise: `result_data` = 32'hFFFFFFFF, and `heap_ptr` is unchanged.
  - Both comparisons use 33-bit arithmetic.
- Code 10, exit: sets `halted`. No result is written.
- Code 4, print string: see Configuration.
- Any other code: `done` and `bad_code` pulse together with no other effect.
- TX: `tx_data` is stable while `tx_valid`=1 and is not retracted until the handshake completes. Stalls indefinitely on `tx_ready`=0.
- FINISH: asserts `done` for one cycle and returns to IDLE.
- Back-to-back syscalls: a new `syscall_req` in the cycle after `done` is a new request.

## Timing
- Reset values:
  - `stall`: follows `syscall_req`.
  - `done`, `result_we`, `tx_valid`, `mem_req`, `halted`, `bad_code`: 0.
  - `result_data`: 0.
  - `tx_data`: 0.
  - `heap_ptr`: `HEAP_BASE`.
  - FSM: IDLE.
- Reset mid-service aborts the service immediately. There is no partial `done` and no heap update.
- sbrk / exit / unknown code: request seen in cycle 0, `done` in cycle 2.
- Print char with `tx_ready` tied high: `tx_valid` in cycle 2, `done` in cycle 3.
- Print int: at most 1 sign + 10 digit-search steps + per-digit subtraction cycles; bounded by 110 cycles with `tx_ready`=1.
- `result_we` and `done` are coincident. `heap_ptr` updates on the same edge.

## Configuration
- `SYSCALL_PRINT_STR_EN` defined:
  - Code 4 prints the NUL-terminated string at `a0`.
  - STR_FETCH holds `mem_req`=1 with `mem_addr = {addr[31:2],2'b00}` until `mem_ack`; the FSM then captures `mem_rdata`.
  - STR_EMIT selects byte lane `addr[1:0]` (lane k = `rdata[8k+7:8k]`, little-endian). On 0x00 it goes to FINISH; otherwise it transmits the byte, increments `addr`, and refetches when `addr[1:0]` wraps to 0.
- Undefined: the memory port is absent, `mem_req` is not driven, and code 4 is treated as unknown (`bad_code`).

## Test plan
- Heap allocation: v0=9, a0=5 from reset -> `result_data`=0x10000000 with `result_we`. Next v0=9, a0=4 -> 0x10000008.
- Heap exhaustion: v0=9, a0=0xF8 after one 8-byte allocation -> 0xFFFFFFFF, `heap_ptr` stays 0x10000008. Then a0=0xF4 -> 0x10000008.
- Print int: v0=1, a0=0xFFFFFF85 (-123) -> bytes 2D 31 32 33. a0=0 -> 30. a0=0x80000000 -> "-2147483648". `tx_ready` toggled randomly yields no drop or duplicate.
- Exit: v0=10 -> `done`, `halted`=1. A subsequent `syscall_req` gives no `done` and `stall` stays high. Asserting `reset` low clears `halted`.
- Reset and unknown code: asynchronous reset low during print int after 2 bytes -> all outputs at reset values, `heap_ptr`=HEAP_BASE. v0=77 -> `bad_code` with `done`.
- Print string (macro defined): "Hi\0" at 0x10000002 spanning a word boundary -> bytes 48 69, two `mem_req` transactions, then `done`.
